// File: rtl/mac_package.sv
// rtl/mac_package.sv - shared types, sizes and requester IDs for the MAC TCDM arbiter
package mac_package;

   localparam int MAC_TCDM_NB_REQ     = 5;
   localparam int MAC_TCDM_ADDR_WIDTH = 32;
   localparam int MAC_TCDM_DATA_WIDTH = 32;

   typedef enum logic [2:0] {
      MAC_REQ_A   = 3'd0,
      MAC_REQ_B   = 3'd1,
      MAC_REQ_C   = 3'd2,
      MAC_REQ_D   = 3'd3,
      MAC_REQ_DBG = 3'd4
   } mac_req_id_e;

   typedef struct packed {
      logic [MAC_TCDM_ADDR_WIDTH-1:0]   add;
      logic                             wen;
      logic [MAC_TCDM_DATA_WIDTH/8-1:0] be;
      logic [MAC_TCDM_DATA_WIDTH-1:0]   data;
   } tcdm_req_t;

   typedef struct packed {
      logic [MAC_TCDM_DATA_WIDTH-1:0] rdata;
      logic                           rvalid;
   } tcdm_resp_t;

   // Round-robin successor of a granted index, wrapping at nb.
   function automatic int next_ptr(input int sel, input int nb);
      return (sel == nb - 1) ? 0 : sel + 1;
   endfunction

endpackage

// File: rtl/mac_rr_picker.sv
// rtl/mac_rr_picker.sv - combinational cyclic first-one picker starting at ptr
module mac_rr_picker
   import mac_package::*;
#(
   parameter int NB_REQ = MAC_TCDM_NB_REQ,
   parameter int IW     = $clog2(NB_REQ)
) (
   input  logic [NB_REQ-1:0] req,
   input  logic [IW-1:0]     ptr,
   output logic [NB_REQ-1:0] onehot,
   output logic [IW-1:0]     idx,
   output logic              valid
);

   always_comb begin
      int j;
      onehot = '0;
      idx    = '0;
      valid  = 1'b0;
      j      = 0;
      for (int i = 0; i < NB_REQ; i++) begin
         j = (int'(ptr) + i) % NB_REQ;
         if (!valid && req[j]) begin
            valid     = 1'b1;
            idx       = IW'(j);
            onehot[j] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mac_tcdm_arbiter.sv
// rtl/mac_tcdm_arbiter.sv - round-robin TCDM port sharing with grant lock and ID-routed responses
// Optional debug priority: define MAC_TCDM_ARB_DBG_PRIO_EN.
module mac_tcdm_arbiter
   import mac_package::*;
#(
   parameter int NB_REQ     = MAC_TCDM_NB_REQ,
   parameter int ADDR_WIDTH = MAC_TCDM_ADDR_WIDTH,
   parameter int DATA_WIDTH = MAC_TCDM_DATA_WIDTH
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic                           clear_i,
   input  logic                           stall_i,
   input  logic [NB_REQ-1:0]              in_req_i,
   input  logic [NB_REQ*ADDR_WIDTH-1:0]   in_add_i,
   input  logic [NB_REQ-1:0]              in_wen_i,
   input  logic [NB_REQ*DATA_WIDTH/8-1:0] in_be_i,
   input  logic [NB_REQ*DATA_WIDTH-1:0]   in_data_i,
   output logic [NB_REQ-1:0]              in_gnt_o,
   output logic [NB_REQ-1:0]              in_rvalid_o,
   output logic [DATA_WIDTH-1:0]          in_rdata_o,
   output logic                           out_req_o,
   output logic [ADDR_WIDTH-1:0]          out_add_o,
   output logic                           out_wen_o,
   output logic [DATA_WIDTH/8-1:0]        out_be_o,
   output logic [DATA_WIDTH-1:0]          out_data_o,
   input  logic                           out_gnt_i,
   input  logic                           out_rvalid_i,
   input  logic [DATA_WIDTH-1:0]          out_rdata_i,
   output logic                           busy_o,
   output logic [31:0]                    gnt_cnt_o
);

   localparam int IW = $clog2(NB_REQ);
   localparam int BW = DATA_WIDTH / 8;
   localparam logic [IW-1:0] DBG_ID = IW'(NB_REQ - 1);
`ifdef MAC_TCDM_ARB_DBG_PRIO_EN
   localparam bit DBG_PRIO = 1'b1;
`else
   localparam bit DBG_PRIO = 1'b0;
`endif

   logic [IW-1:0]     ptr_q, sel_q, resp_id_q, pick_idx, cur_sel;
   logic              lock_q, resp_pend_q, pick_valid, cur_valid;
   logic              active, dbg_win, stall_sel, grant;
   logic [NB_REQ-1:0] rr_req, pick_onehot, cur_onehot;
   logic [31:0]       gnt_cnt_q;

   // Outputs are forced quiet while reset or clear is applied.
   assign active = !rst_i && !clear_i;
   assign rr_req = stall_i ? '0 : in_req_i;

   mac_rr_picker #(.NB_REQ(NB_REQ), .IW(IW)) u_picker (
      .req    (rr_req),
      .ptr    (ptr_q),
      .onehot (pick_onehot),
      .idx    (pick_idx),
      .valid  (pick_valid)
   );

   // A locked debug selection keeps ignoring stall when priority is enabled.
   assign stall_sel = stall_i && !(DBG_PRIO && (sel_q == DBG_ID));
   assign dbg_win   = DBG_PRIO && !lock_q && in_req_i[NB_REQ-1];

   always_comb begin
      cur_sel    = pick_idx;
      cur_valid  = pick_valid;
      cur_onehot = pick_onehot;
      if (lock_q) begin
         cur_sel    = sel_q;
         cur_valid  = in_req_i[sel_q] && !stall_sel;
         cur_onehot = NB_REQ'(1) << sel_q;
      end else if (dbg_win) begin
         cur_sel    = DBG_ID;
         cur_valid  = 1'b1;
         cur_onehot = NB_REQ'(1) << DBG_ID;
      end
   end

   assign out_req_o = active && cur_valid;
   assign grant     = out_req_o && out_gnt_i;

   always_comb begin
      int s;
      s = int'(cur_sel);
      out_add_o  = '0;
      out_wen_o  = 1'b0;
      out_be_o   = '0;
      out_data_o = '0;
      if (out_req_o) begin
         out_add_o  = in_add_i[s*ADDR_WIDTH +: ADDR_WIDTH];
         out_wen_o  = in_wen_i[s];
         out_be_o   = in_be_i[s*BW +: BW];
         out_data_o = in_data_i[s*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   assign in_gnt_o    = grant ? cur_onehot : '0;
   assign in_rvalid_o = (active && out_rvalid_i && resp_pend_q) ? (NB_REQ'(1) << resp_id_q) : '0;
   assign in_rdata_o  = active ? out_rdata_i : '0;
   assign busy_o      = lock_q | resp_pend_q;
   assign gnt_cnt_o   = gnt_cnt_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ptr_q       <= '0;
         lock_q      <= 1'b0;
         sel_q       <= '0;
         resp_pend_q <= 1'b0;
         resp_id_q   <= '0;
         gnt_cnt_q   <= '0;
      end else if (clear_i) begin
         ptr_q       <= '0;
         lock_q      <= 1'b0;
         sel_q       <= '0;
         resp_pend_q <= 1'b0;
         resp_id_q   <= '0;
         gnt_cnt_q   <= '0;
      end else begin
         resp_pend_q <= grant;
         if (grant) begin
            resp_id_q <= cur_sel;
            gnt_cnt_q <= gnt_cnt_q + 32'd1;
            lock_q    <= 1'b0;
            if (!(DBG_PRIO && (cur_sel == DBG_ID)))
               ptr_q <= IW'(next_ptr(int'(cur_sel), NB_REQ));
         end else if (out_req_o) begin
            lock_q <= 1'b1;
            sel_q  <= cur_sel;
         end else if (!(lock_q && stall_sel)) begin
            lock_q <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_mac_tcdm_arbiter.sv
// tb/tb_mac_tcdm_arbiter.sv - scenario bench for mac_tcdm_arbiter with response scoreboard
module tb_mac_tcdm_arbiter;

   localparam int NB = 5;
   localparam int AW = 32;
   localparam int DW = 32;

   logic             clk = 1'b0;
   logic             rst, clear, stall;
   logic [NB-1:0]    in_req, in_wen;
   logic [NB*AW-1:0] in_add;
   logic [NB*DW/8-1:0] in_be;
   logic [NB*DW-1:0] in_data;
   logic [NB-1:0]    in_gnt, in_rvalid;
   logic [DW-1:0]    in_rdata;
   logic             out_req, out_wen, out_gnt, out_rvalid, busy;
   logic [AW-1:0]    out_add;
   logic [DW/8-1:0]  out_be;
   logic [DW-1:0]    out_data, out_rdata;
   logic [31:0]      gnt_cnt;

   int checks = 0;
   int passed = 0;
   int exp_q[$];
   int id;

   always #5 clk = ~clk;

   mac_tcdm_arbiter dut (
      .clk_i(clk), .rst_i(rst), .clear_i(clear), .stall_i(stall),
      .in_req_i(in_req), .in_add_i(in_add), .in_wen_i(in_wen), .in_be_i(in_be), .in_data_i(in_data),
      .in_gnt_o(in_gnt), .in_rvalid_o(in_rvalid), .in_rdata_o(in_rdata),
      .out_req_o(out_req), .out_add_o(out_add), .out_wen_o(out_wen), .out_be_o(out_be), .out_data_o(out_data),
      .out_gnt_i(out_gnt), .out_rvalid_i(out_rvalid), .out_rdata_i(out_rdata),
      .busy_o(busy), .gnt_cnt_o(gnt_cnt)
   );

   task set_fields;
      for (int i = 0; i < NB; i++) begin
         in_add[i*AW +: AW]    = 32'h1000 + i*4;
         in_data[i*DW +: DW]   = 32'hD000_0000 + i;
         in_be[i*DW/8 +: DW/8] = 4'(i + 1);
      end
      in_wen = 5'b10101;
   endtask

   task do_clear;
      @(negedge clk);
      in_req = '0; out_gnt = 1'b0; out_rvalid = 1'b0; stall = 1'b0; clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
   endtask

   task test_reset;
      @(negedge clk);
      in_req = '1; out_gnt = 1'b1; out_rvalid = 1'b1; out_rdata = 32'h5555_AAAA;
      #1;
      checks++; if (out_req !== 1'b0) $display("FAIL reset_out_req act=%0h exp=0", out_req); else passed++;
      checks++; if (in_gnt !== 5'b0 || in_rvalid !== 5'b0) $display("FAIL reset_gnt_rvalid act=%b/%b exp=0", in_gnt, in_rvalid); else passed++;
      checks++; if (busy !== 1'b0 || gnt_cnt !== 32'd0 || in_rdata !== 32'd0) $display("FAIL reset_state act=%0h/%0h/%0h exp=0", busy, gnt_cnt, in_rdata); else passed++;
      @(negedge clk);
      in_req = '0; out_gnt = 1'b0; out_rvalid = 1'b0; rst = 1'b0;
   endtask

   task test_round_robin;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         in_req = '1; out_gnt = 1'b1;
         out_rvalid = (exp_q.size() != 0); out_rdata = 32'hA000_0000 + k;
         #1;
         checks++; if (in_gnt !== 5'(1 << (k % 5))) $display("FAIL rr_gnt k=%0d act=%b exp=%b", k, in_gnt, 5'(1 << (k % 5))); else passed++;
         checks++; if (out_add !== 32'h1000 + (k % 5)*4) $display("FAIL rr_add k=%0d act=%h exp=%h", k, out_add, 32'h1000 + (k % 5)*4); else passed++;
         if (out_rvalid) begin
            id = exp_q.pop_front();
            checks++; if (in_rvalid !== 5'(1 << id) || in_rdata !== out_rdata) $display("FAIL rr_rvalid k=%0d act=%b exp=%b", k, in_rvalid, 5'(1 << id)); else passed++;
         end
         exp_q.push_back(k % 5);
      end
      @(negedge clk);
      in_req = '0; out_gnt = 1'b0; out_rvalid = 1'b1; out_rdata = 32'h0BAD_F00D;
      #1;
      id = exp_q.pop_front();
      checks++; if (in_rvalid !== 5'(1 << id)) $display("FAIL rr_last_rvalid act=%b exp=%b", in_rvalid, 5'(1 << id)); else passed++;
      @(negedge clk);
      out_rvalid = 1'b0;
   endtask

   task test_lock;
      do_clear();
      in_req = 5'b00100; out_gnt = 1'b0;
      #1;
      checks++; if (out_req !== 1'b1 || out_add !== 32'h1008) $display("FAIL lock_c1 act=%0h/%h exp=1/1008", out_req, out_add); else passed++;
      for (int c = 2; c <= 3; c++) begin
         @(negedge clk);
         in_req = 5'b00101;
         #1;
         checks++; if (out_add !== 32'h1008 || in_gnt !== 5'b0 || busy !== 1'b1) $display("FAIL lock_hold c=%0d act=%h/%b/%0h exp=1008/0/1", c, out_add, in_gnt, busy); else passed++;
      end
      @(negedge clk);
      out_gnt = 1'b1;
      #1;
      checks++; if (in_gnt !== 5'b00100) $display("FAIL lock_gnt act=%b exp=00100", in_gnt); else passed++;
      exp_q.push_back(2);
      @(negedge clk);
      out_rvalid = 1'b1; out_rdata = 32'h1111_2222;
      #1;
      checks++; if (in_gnt !== 5'b00001) $display("FAIL lock_next_gnt act=%b exp=00001", in_gnt); else passed++;
      id = exp_q.pop_front();
      checks++; if (in_rvalid !== 5'(1 << id)) $display("FAIL lock_rvalid2 act=%b exp=%b", in_rvalid, 5'(1 << id)); else passed++;
      exp_q.push_back(0);
      @(negedge clk);
      in_req = '0; out_gnt = 1'b0; out_rdata = 32'h3333_4444;
      #1;
      id = exp_q.pop_front();
      checks++; if (in_rvalid !== 5'(1 << id)) $display("FAIL lock_rvalid0 act=%b exp=%b", in_rvalid, 5'(1 << id)); else passed++;
      @(negedge clk);
      out_rvalid = 1'b0;
   endtask

   task test_read_response;
      do_clear();
      in_add[2*AW +: AW] = 32'h0000_0100;
      in_req = 5'b00100; out_gnt = 1'b1;
      #1;
      checks++; if (out_add !== 32'h100 || out_wen !== 1'b1 || in_gnt !== 5'b00100) $display("FAIL read_req act=%h/%0h/%b exp=100/1/00100", out_add, out_wen, in_gnt); else passed++;
      checks++; if (out_be !== 4'h3 || out_data !== 32'hD000_0002) $display("FAIL read_fields act=%h/%h exp=3/d0000002", out_be, out_data); else passed++;
      exp_q.push_back(2);
      @(negedge clk);
      in_req = '0; out_gnt = 1'b0; out_rvalid = 1'b1; out_rdata = 32'hDEAD_BEEF;
      #1;
      id = exp_q.pop_front();
      checks++; if (in_rvalid !== 5'(1 << id) || in_rdata !== 32'hDEAD_BEEF || busy !== 1'b1) $display("FAIL read_rvalid act=%b/%h/%0h exp=%b/deadbeef/1", in_rvalid, in_rdata, busy, 5'(1 << id)); else passed++;
      @(negedge clk);
      out_rdata = 32'h1234_5678;
      #1;
      checks++; if (in_rvalid !== 5'b0 || busy !== 1'b0) $display("FAIL read_spurious act=%b/%0h exp=0/0", in_rvalid, busy); else passed++;
      @(negedge clk);
      out_rvalid = 1'b0;
      in_add[2*AW +: AW] = 32'h1008;
   endtask

   task test_stall;
      do_clear();
      in_req = 5'b01000; out_gnt = 1'b0;
      #1;
      checks++; if (out_req !== 1'b1 || out_add !== 32'h100C) $display("FAIL stall_pre act=%0h/%h exp=1/100c", out_req, out_add); else passed++;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         stall = 1'b1; in_req = 5'b01001; out_gnt = 1'b1;
         #1;
         checks++; if (out_req !== 1'b0 || in_gnt !== 5'b0 || busy !== 1'b1) $display("FAIL stall_hold c=%0d act=%0h/%b/%0h exp=0/0/1", c, out_req, in_gnt, busy); else passed++;
      end
      @(negedge clk);
      stall = 1'b0;
      #1;
      checks++; if (in_gnt !== 5'b01000) $display("FAIL stall_resume act=%b exp=01000", in_gnt); else passed++;
      exp_q.push_back(3);
      @(negedge clk);
      stall = 1'b1; out_rvalid = 1'b1; out_rdata = 32'hCAFE_0003;
      #1;
      id = exp_q.pop_front();
      checks++; if (out_req !== 1'b0 || in_rvalid !== 5'(1 << id) || in_rdata !== 32'hCAFE_0003) $display("FAIL stall_rvalid act=%0h/%b exp=0/%b", out_req, in_rvalid, 5'(1 << id)); else passed++;
      @(negedge clk);
      stall = 1'b0; out_rvalid = 1'b0;
      #1;
      checks++; if (in_gnt !== 5'b00001) $display("FAIL stall_next act=%b exp=00001", in_gnt); else passed++;
      exp_q.push_back(0);
      @(negedge clk);
      in_req = '0; out_gnt = 1'b0; out_rvalid = 1'b1; out_rdata = 32'hCAFE_0000;
      #1;
      id = exp_q.pop_front();
      checks++; if (in_rvalid !== 5'(1 << id)) $display("FAIL stall_last act=%b exp=%b", in_rvalid, 5'(1 << id)); else passed++;
      @(negedge clk);
      out_rvalid = 1'b0;
   endtask

   task test_dbg_prio;
      do_clear();
      in_req = 5'b10011; stall = 1'b1; out_gnt = 1'b1;
      #1;
`ifdef MAC_TCDM_ARB_DBG_PRIO_EN
      checks++; if (in_gnt !== 5'b10000 || out_req !== 1'b1) $display("FAIL dbg_prio act=%b/%0h exp=10000/1", in_gnt, out_req); else passed++;
      exp_q.push_back(4);
`else
      checks++; if (in_gnt !== 5'b00000 || out_req !== 1'b0) $display("FAIL dbg_stalled act=%b/%0h exp=00000/0", in_gnt, out_req); else passed++;
`endif
      @(negedge clk);
      in_req = '0; stall = 1'b0; out_gnt = 1'b0;
      out_rvalid = (exp_q.size() != 0); out_rdata = 32'hDB9D_B900;
      #1;
      if (out_rvalid) begin
         id = exp_q.pop_front();
         checks++; if (in_rvalid !== 5'(1 << id)) $display("FAIL dbg_rvalid act=%b exp=%b", in_rvalid, 5'(1 << id)); else passed++;
      end
      @(negedge clk);
      out_rvalid = 1'b0;
   endtask

   task test_count_clear;
      do_clear();
      in_req = '1; out_gnt = 1'b1;
      for (int c = 1; c < 10; c++) @(negedge clk);
      @(negedge clk);
      in_req = '0; out_gnt = 1'b0; clear = 1'b1;
      #1;
      checks++; if (gnt_cnt !== 32'd10) $display("FAIL cnt_before act=%0d exp=10", gnt_cnt); else passed++;
      @(negedge clk);
      clear = 1'b0; in_req = '1; out_gnt = 1'b1;
      #1;
      checks++; if (gnt_cnt !== 32'd0 || busy !== 1'b0) $display("FAIL cnt_after act=%0d/%0h exp=0/0", gnt_cnt, busy); else passed++;
      checks++; if (in_gnt !== 5'b00001) $display("FAIL ptr_restart act=%b exp=00001", in_gnt); else passed++;
      @(negedge clk);
      in_req = 5'b00100; out_gnt = 1'b0;
      @(negedge clk);
      #1;
      checks++; if (busy !== 1'b1) $display("FAIL mid_lock_busy act=%0h exp=1", busy); else passed++;
      in_req = '1; out_gnt = 1'b1; out_rvalid = 1'b1;
      #1;
      rst = 1'b1;
      #1;
      checks++; if (out_req !== 1'b0 || in_gnt !== 5'b0 || in_rvalid !== 5'b0 || out_add !== 32'd0) $display("FAIL async_rst_out act=%0h/%b/%b/%h exp=0", out_req, in_gnt, in_rvalid, out_add); else passed++;
      checks++; if (busy !== 1'b0 || gnt_cnt !== 32'd0) $display("FAIL async_rst_state act=%0h/%0d exp=0/0", busy, gnt_cnt); else passed++;
      @(negedge clk);
      in_req = '0; out_gnt = 1'b0; out_rvalid = 1'b0; rst = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1; clear = 1'b0; stall = 1'b0;
      in_req = '0; out_gnt = 1'b0; out_rvalid = 1'b0; out_rdata = '0;
      in_add = '0; in_wen = '0; in_be = '0; in_data = '0;
      set_fields();
      test_reset();
      test_round_robin();
      test_lock();
      test_read_response();
      test_stall();
      test_dbg_prio();
      test_count_clear();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
